// File: rtl/muldiv_seq_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_seq_unit : iterative RV32M multiply/divide, one result bit per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_seq_unit #(
  parameter int NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [2:0]         i_funct3,
  input  logic [NB_DATA-1:0] i_rs1,
  input  logic [NB_DATA-1:0] i_rs2,
  input  logic               i_flush,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_result
);

  localparam int               CNT_W    = $clog2(NB_DATA) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_DATA - 1);
  localparam logic [NB_DATA-1:0] MOST_NEG = {1'b1, {(NB_DATA-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [2:0]           op;
  logic [NB_DATA-1:0]   mcand;
  logic [2*NB_DATA-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_q;
  logic                 neg_r;

  logic                 is_div, rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic                 div_zero, div_ovf;
  logic [NB_DATA-1:0]   rs1_mag, rs2_mag, bypass_result;
  logic [NB_DATA:0]     mul_sum, div_shift, div_diff;
  logic [2*NB_DATA-1:0] mul_next, div_next, step_next, mul_fixed;
  logic [NB_DATA-1:0]   quot, rem, final_result;

  // Operand decode: signedness per op, magnitudes and the two bypass cases
  assign is_div        = i_funct3[2];
  assign rs1_signed    = is_div ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
  assign rs2_signed    = is_div ? ~i_funct3[0] : ~i_funct3[1];
  assign rs1_neg       = rs1_signed & i_rs1[NB_DATA-1];
  assign rs2_neg       = rs2_signed & i_rs2[NB_DATA-1];
  assign rs1_mag       = rs1_neg ? -i_rs1 : i_rs1;
  assign rs2_mag       = rs2_neg ? -i_rs2 : i_rs2;
  assign div_zero      = is_div & (i_rs2 == '0);
  assign div_ovf       = is_div & ~i_funct3[0] & (i_rs1 == MOST_NEG) & (i_rs2 == '1);
  assign bypass_result = div_zero ? (i_funct3[1] ? i_rs1 : '1)
                                  : (i_funct3[1] ? '0 : i_rs1);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_next  = {mul_sum, acc[NB_DATA-1:1]};
  assign div_shift = acc[2*NB_DATA-1:NB_DATA-1];
  assign div_diff  = div_shift - {1'b0, mcand};
  assign div_next  = div_diff[NB_DATA] ? {div_shift[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b0}
                                       : {div_diff[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b1};
  assign step_next = op[2] ? div_next : mul_next;

  assign mul_fixed = neg_q ? -mul_next : mul_next;
  assign quot      = neg_q ? -div_next[NB_DATA-1:0] : div_next[NB_DATA-1:0];
  assign rem       = neg_r ? -div_next[2*NB_DATA-1:NB_DATA] : div_next[2*NB_DATA-1:NB_DATA];

  always_comb begin
    final_result = mul_fixed[2*NB_DATA-1:NB_DATA];
    if (op[2]) begin
      final_result = op[1] ? rem : quot;
    end else if (op[1:0] == 2'b00) begin
      final_result = mul_fixed[NB_DATA-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      op       <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else if (i_flush) begin
      state  <= IDLE;
      cnt    <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
          if (i_start) begin
            op <= i_funct3;
            if (div_zero || div_ovf) begin
              state    <= DONE;
              o_done   <= 1'b1;
              o_result <= bypass_result;
            end else begin
              state  <= CALC;
              o_busy <= 1'b1;
              cnt    <= '0;
              mcand  <= is_div ? rs2_mag : rs1_mag;
              acc    <= {{NB_DATA{1'b0}}, (is_div ? rs1_mag : rs2_mag)};
              neg_q  <= rs1_neg ^ rs2_neg;
              neg_r  <= rs1_neg;
            end
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state    <= DONE;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_result <= final_result;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_seq_unit : scoreboard bench for muldiv_seq_unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_seq_unit;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst, start, flush;
  logic [2:0]    f3;
  logic [N-1:0]  rs1, rs2;
  logic          busy, done;
  logic [N-1:0]  result;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [N-1:0] res;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [N-1:0] held;

  muldiv_seq_unit #(.NB_DATA(N)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_funct3 (f3),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full-width arithmetic plus the RISC-V corner-case rules
  function automatic logic [N-1:0] model(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [63:0] sx, sy, p;
    logic [63:0]        pu;
    logic signed [N-1:0] t;
    sx = {{32{a[N-1]}}, a};
    sy = {{32{b[N-1]}}, b};
    case (f)
      3'b000: begin p = sx * sy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * $signed({32'b0, b}); return p[63:32]; end
      3'b011: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        t = $signed(a) / $signed(b);
        return t;
      end
      3'b101: return (b == 0) ? '1 : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        t = $signed(a) % $signed(b);
        return t;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return N + 1;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check_val("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("result", result, mon_e.res);
        check_val("latency", cyc - mon_e.acc_cyc + 1, mon_e.lat);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    f3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    e.res     = model(f, a, b);
    e.lat     = model_lat(f, a, b);
    e.acc_cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_n);
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) return;
    end
    check_val("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    int bn;
    issue(f, a, b);
    wait_done(bn);
    check_val("busy_cycles", bn, (model_lat(f, a, b) == 1) ? 0 : N);
    @(negedge clk);
    check_val("done_one_cycle", done, 0);
  endtask

  initial begin
    int bn;
    logic [2:0]   rf;
    logic [N-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_result", result, 0);
    rst = 1'b0;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD);        check_val("mul_7x-3", result, 32'hFFFF_FFEB);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000); check_val("mulh_min", result, 32'h4000_0000);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF); check_val("mulhu_max", result, 32'hFFFF_FFFE);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF); check_val("mulhsu_max", result, 32'hFFFF_FFFF);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2);        check_val("div_-7/2", result, 32'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2);        check_val("rem_-7/2", result, 32'hFFFF_FFFF);
    run_op(3'b101, 32'd100, 32'd7);              check_val("divu_100/7", result, 32'd14);
    run_op(3'b111, 32'd100, 32'd7);              check_val("remu_100/7", result, 32'd2);
    run_op(3'b101, 32'd10, 32'd0);               check_val("divu_by0", result, 32'hFFFF_FFFF);
    run_op(3'b110, 32'd10, 32'd0);               check_val("rem_by0", result, 32'd10);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF); check_val("div_ovf", result, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF); check_val("rem_ovf", result, 32'd0);

    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      run_op(rf, ra, rb);
    end

    // A start arriving mid-iteration must not disturb the running op
    issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) @(negedge clk);
    f3 = 3'b100; rs1 = 32'd1; rs2 = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bn);
    @(negedge clk);

    // Back-to-back: B accepted in A's DONE cycle, A's result held until B ends
    issue(3'b000, 32'd3, 32'd4);
    wait_done(bn);
    issue(3'b101, 32'd100, 32'd7);
    @(negedge clk);
    check_val("b2b_no_gap", busy, 1);
    check_val("b2b_hold", result, 32'd12);
    repeat (20) @(negedge clk);
    check_val("b2b_hold_late", result, 32'd12);
    wait_done(bn);
    @(negedge clk);
    held = result;

    // Flush mid-CALC
    issue(3'b000, 32'd5, 32'd6);
    void'(sb.pop_back());
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check_val("flush_busy", busy, 0);
    check_val("flush_done", done, 0);
    check_val("flush_result", result, held);
    repeat (40) @(negedge clk);

    // Flush beats start in IDLE
    f3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_val("flush_prio_busy", busy, 0);
    repeat (3) @(negedge clk);
    run_op(3'b000, 32'd9, 32'd9); check_val("after_flush", result, 32'd81);

    // Reset mid-CALC
    issue(3'b100, 32'd1000, 32'd3);
    void'(sb.pop_back());
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_result", result, 0);
    repeat (40) @(negedge clk);
    run_op(3'b110, 32'hFFFF_FC18, 32'd7);

    check_val("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq_unit.md
MULDIV_SEQ_UNIT -- requirements
Module: muldiv_seq_unit

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, giving the operand/result width.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port i_start, input, 1: request to start an operation.
REQ-005 SHALL have port i_funct3, input, 3: RV32M op (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 SHALL have port i_rs1, input, NB_DATA: multiplicand/dividend.
REQ-007 SHALL have port i_rs2, input, NB_DATA: multiplier/divisor.
REQ-008 SHALL have port i_flush, input, 1: abort the current operation (pipeline flush).
REQ-009 SHALL have port o_busy, output, 1: iteration in progress; pipeline stall request.
REQ-010 SHALL have port o_done, output, 1: single-cycle result-valid pulse.
REQ-011 SHALL have port o_result, output, NB_DATA: result of the last completed operation.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 SHALL accept a request when i_start=1, i_flush=0 and state is IDLE or DONE; on acceptance SHALL latch i_funct3, i_rs1 and i_rs2.
REQ-014 SHALL ignore i_start while in CALC; latched operands SHALL NOT change.
REQ-015 Normal accept SHALL go to CALC, iterate exactly NB_DATA cycles, then go to DONE; o_done SHALL be 1 exactly NB_DATA+1 cycles after the accepting edge.
REQ-016 Multiply SHALL use radix-2 shift-add on operand magnitudes into a 2*NB_DATA product, applying sign correction on entry to DONE.
REQ-016a Multiply signedness: MUL and MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
REQ-016b Multiply result: MUL returns product[NB_DATA-1:0]; MULH, MULHSU and MULHU return product[2*NB_DATA-1:NB_DATA].
REQ-017 Divide SHALL use restoring division on magnitudes; quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1) (DIV/REM only).
REQ-018 Divide by zero SHALL bypass CALC (IDLE/DONE -> DONE directly, o_done one cycle after accept): DIV/DIVU return all ones; REM/REMU return rs1.
REQ-019 Signed overflow (rs1 = most negative, rs2 = -1, DIV/REM) SHALL bypass CALC identically: DIV returns rs1; REM returns 0.
REQ-020 o_busy SHALL be 1 only in CALC; o_done SHALL be 1 only in DONE, for exactly one cycle.
REQ-021 Without a new accept, DONE SHALL return to IDLE on the next cycle.
REQ-021a A start in DONE SHALL be accepted and give back-to-back operation.
REQ-022 o_result SHALL update only on entry to DONE and hold until the next DONE.
REQ-023 i_flush=1 in any state SHALL force IDLE on the next edge with no o_done pulse and o_result unchanged.
REQ-023a i_flush SHALL take priority over a simultaneous i_start.
REQ-024 All arithmetic SHALL be width-exact with no X propagation; iteration counter width SHALL be clog2(NB_DATA)+1.

Reset
REQ-025 i_rst=1 SHALL on the next edge force IDLE, o_busy=0, o_done=0, o_result=0, and clear counter and internal registers.
REQ-025a i_rst SHALL override i_start and i_flush.
REQ-026 Reset asserted mid-CALC SHALL abort the operation with no o_done pulse.

Verification
REQ-027 MUL rs1=7, rs2=0xFFFFFFFD -> o_busy high 32 cycles; o_done pulses 33 cycles after accept; o_result=0xFFFFFFEB.
REQ-028 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-030 DIVU 10 / 0 -> o_done one cycle after accept, result 0xFFFFFFFF; REM 10 / 0 -> 10; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with o_busy never asserted.
REQ-031 Flush at CALC cycle 10 -> IDLE next cycle, no o_done, o_result keeps prior value; new start then completes normally.
REQ-032 Reset at CALC cycle 5 -> outputs 0 next cycle, no o_done; start during DONE of op A (MUL 3 x 4) -> op B begins with no idle gap and o_result=12 held until B's DONE.
